regfile_scoreboard: RTL and testbench

- Register status controller placed between dispatch/ROB and the 32x32 architectural register file.
- Tracks, per architectural register, whether a younger in-flight ROB entry will write it, and which tag.
- Reports operand readiness (or a producing tag) to dispatch.
- Sequences ROB commits into registered register-file write strobes.
- Handles pipeline flush with a one-cycle recovery state.

---
 rtl/regfile_scoreboard.sv | 162 ++++++++++++++++
 tb/tb_regfile_scoreboard.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : Register status scoreboard between dispatch/ROB and the
//            architectural register file. Tracks per-register busy/tag,
//            answers operand lookups, turns commits into registered
//            register-file writes and recovers from pipeline flushes.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
  parameter int TAG_W = 3,
  parameter int NREG  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [4:0]       disp_rd,
  input  logic [TAG_W-1:0] disp_tag,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  output logic             rs1_busy,
  output logic [TAG_W-1:0] rs1_tag,
  output logic             rs1_fwd,
  output logic             rs2_busy,
  output logic [TAG_W-1:0] rs2_tag,
  output logic             rs2_fwd,
  input  logic             commit_valid,
  input  logic [4:0]       commit_rd,
  input  logic [TAG_W-1:0] commit_tag,
  input  logic [31:0]      commit_data,
  input  logic             flush,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata
);

  localparam int RW = 5;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic [TAG_W-1:0]  tag_q [NREG];
  logic [TAG_W-1:0]  tag_d [NREG];
  logic              rf_we_q, rf_we_d;
  logic [RW-1:0]     rf_waddr_q, rf_waddr_d;
  logic [31:0]       rf_wdata_q, rf_wdata_d;
  logic              disp_fire;

  // FSM next state: any sampled flush lands in (or keeps us in) RECOVER
  always_comb begin
    state_d    = ST_RUN;
    disp_ready = 1'b0;
    if (flush) begin
      state_d = ST_RECOVER;
    end
    if (state_q == ST_RUN) begin
      disp_ready = 1'b1;
    end
  end

  // A dispatch allocates only when accepted, not flushed, and not to x0
  assign disp_fire = disp_valid & disp_ready & ~flush & (disp_rd != '0);

  // Table next state: flush wipes all, else tag-matched commit clears, dispatch overrides
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NREG; i++) begin
      tag_d[i] = tag_q[i];
    end
    if (flush) begin
      busy_d = '0;
      for (int i = 0; i < NREG; i++) begin
        tag_d[i] = '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (commit_valid && (commit_rd == i[RW-1:0]) && (tag_q[i] == commit_tag)) begin
          busy_d[i] = 1'b0;
        end
        if (disp_fire && (disp_rd == i[RW-1:0])) begin
          busy_d[i] = 1'b1;
          tag_d[i]  = disp_tag;
        end
      end
    end
  end

  // Register-file write staging: one cycle after the commit; x0 is never written
  always_comb begin
    rf_we_d    = commit_valid && (commit_rd != '0);
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (commit_valid) begin
      rf_waddr_d = commit_rd;
      rf_wdata_d = commit_data;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      busy_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      for (int i = 0; i < NREG; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      for (int i = 0; i < NREG; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  // rs1 lookup from pre-edge table state, forwarding a matching commit
  always_comb begin
    rs1_busy = 1'b0;
    rs1_tag  = '0;
    rs1_fwd  = 1'b0;
    if ((rs1 != '0) && busy_q[rs1]) begin
      if (commit_valid && (commit_rd == rs1) && (commit_tag == tag_q[rs1])) begin
        rs1_fwd = 1'b1;
      end else begin
        rs1_busy = 1'b1;
        rs1_tag  = tag_q[rs1];
      end
    end
  end

  // rs2 lookup, identical rules to rs1
  always_comb begin
    rs2_busy = 1'b0;
    rs2_tag  = '0;
    rs2_fwd  = 1'b0;
    if ((rs2 != '0) && busy_q[rs2]) begin
      if (commit_valid && (commit_rd == rs2) && (commit_tag == tag_q[rs2])) begin
        rs2_fwd = 1'b1;
      end else begin
        rs2_busy = 1'b1;
        rs2_tag  = tag_q[rs2];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_scoreboard
// Purpose  : Self-checking bench for regfile_scoreboard: directed vector
//            table, hand sequences for flush/reset corners, and random
//            traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        disp_valid;
  logic        disp_ready;
  logic [4:0]  disp_rd;
  logic [2:0]  disp_tag;
  logic [4:0]  rs1, rs2;
  logic        rs1_busy, rs1_fwd, rs2_busy, rs2_fwd;
  logic [2:0]  rs1_tag, rs2_tag;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [2:0]  commit_tag;
  logic [31:0] commit_data;
  logic        flush;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int pass_cnt  = 0;
  int total_cnt = 0;

  regfile_scoreboard #(.TAG_W(3), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_rd(disp_rd), .disp_tag(disp_tag),
    .rs1(rs1), .rs2(rs2),
    .rs1_busy(rs1_busy), .rs1_tag(rs1_tag), .rs1_fwd(rs1_fwd),
    .rs2_busy(rs2_busy), .rs2_tag(rs2_tag), .rs2_fwd(rs2_fwd),
    .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_tag(commit_tag), .commit_data(commit_data),
    .flush(flush),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dv;  logic [4:0] drd; logic [2:0] dtag;
    logic [4:0]  r1;  logic [4:0] r2;
    logic        cv;  logic [4:0] crd; logic [2:0] ctag; logic [31:0] cdata;
    logic        fl;
    logic        e1b; logic [2:0] e1t; logic e1f;
    logic        e2b; logic [2:0] e2t; logic e2f;
    logic        erdy; logic ewe; logic [4:0] ewa; logic [31:0] ewd;
  } vec_t;

  vec_t vecs [18];

  // Behavioural model state
  bit         busy_m [32];
  logic [2:0] tag_m  [32];
  bit         recov_m;
  bit         we_m;
  logic [4:0] wa_m;
  logic [31:0] wd_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    else pass_cnt++;
  endtask

  task automatic chk_outs(input string tag,
                          input logic e1b, input logic [2:0] e1t, input logic e1f,
                          input logic e2b, input logic [2:0] e2t, input logic e2f,
                          input logic erdy, input logic ewe,
                          input logic [4:0] ewa, input logic [31:0] ewd);
    chk({tag, ".rs1_busy"}, 32'(rs1_busy), 32'(e1b));
    chk({tag, ".rs1_tag"},  32'(rs1_tag),  32'(e1t));
    chk({tag, ".rs1_fwd"},  32'(rs1_fwd),  32'(e1f));
    chk({tag, ".rs2_busy"}, 32'(rs2_busy), 32'(e2b));
    chk({tag, ".rs2_tag"},  32'(rs2_tag),  32'(e2t));
    chk({tag, ".rs2_fwd"},  32'(rs2_fwd),  32'(e2f));
    chk({tag, ".disp_ready"}, 32'(disp_ready), 32'(erdy));
    chk({tag, ".rf_we"},    32'(rf_we),    32'(ewe));
    if (ewe) begin
      chk({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(ewa));
      chk({tag, ".rf_wdata"}, rf_wdata, ewd);
    end
  endtask

  task automatic drive(input logic dv, input logic [4:0] drd, input logic [2:0] dtag,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic cv, input logic [4:0] crd, input logic [2:0] ctag,
                       input logic [31:0] cdata, input logic fl);
    disp_valid = dv; disp_rd = drd; disp_tag = dtag;
    rs1 = r1; rs2 = r2;
    commit_valid = cv; commit_rd = crd; commit_tag = ctag; commit_data = cdata;
    flush = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
  endtask

  // Expected lookup from the model's register status
  function automatic logic [4:0] model_lookup(input logic [4:0] rs);
    logic b, f; logic [2:0] t;
    b = 0; f = 0; t = 0;
    if (rs != 0 && busy_m[rs]) begin
      if (commit_valid && commit_rd == rs && commit_tag == tag_m[rs]) f = 1;
      else begin b = 1; t = tag_m[rs]; end
    end
    return {b, t, f};
  endfunction

  // Advance the model by one clock edge using the currently driven inputs
  task automatic model_edge();
    bit acc;
    acc = disp_valid && !recov_m && !flush && disp_rd != 0;
    if (flush) begin
      for (int i = 0; i < 32; i++) begin busy_m[i] = 0; tag_m[i] = 0; end
    end else begin
      if (commit_valid && tag_m[commit_rd] == commit_tag) busy_m[commit_rd] = 0;
      if (acc) begin busy_m[disp_rd] = 1; tag_m[disp_rd] = disp_tag; end
    end
    we_m = commit_valid && commit_rd != 0;
    if (commit_valid) begin wa_m = commit_rd; wd_m = commit_data; end
    recov_m = flush;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin busy_m[i] = 0; tag_m[i] = 0; end
    recov_m = 0; we_m = 0; wa_m = 0; wd_m = 0;
  endtask

  initial begin
    logic [4:0] l1, l2;
    rst_n = 1'b0;
    idle();
    model_reset();

    //            dv drd dt  r1  r2  cv crd ct  cdata          fl  e1b e1t e1f e2b e2t e2f rdy we wa  wd
    vecs[0]  = '{0, 0,  0,  5,  0,  0, 0,  0, 32'h0,         0,  0,  0,  0,  0,  0,  0,  1, 0, 0,  32'h0};
    vecs[1]  = '{1, 5,  3,  5,  0,  0, 0,  0, 32'h0,         0,  0,  0,  0,  0,  0,  0,  1, 0, 0,  32'h0};
    vecs[2]  = '{0, 0,  0,  5,  5,  0, 0,  0, 32'h0,         0,  1,  3,  0,  1,  3,  0,  1, 0, 0,  32'h0};
    vecs[3]  = '{0, 0,  0,  5,  0,  1, 5,  3, 32'hDEADBEEF,  0,  0,  0,  1,  0,  0,  0,  1, 0, 0,  32'h0};
    vecs[4]  = '{0, 0,  0,  5,  0,  0, 0,  0, 32'h0,         0,  0,  0,  0,  0,  0,  0,  1, 1, 5,  32'hDEADBEEF};
    vecs[5]  = '{1, 7,  1,  7,  0,  0, 0,  0, 32'h0,         0,  0,  0,  0,  0,  0,  0,  1, 0, 0,  32'h0};
    vecs[6]  = '{1, 7,  4,  7,  0,  0, 0,  0, 32'h0,         0,  1,  1,  0,  0,  0,  0,  1, 0, 0,  32'h0};
    vecs[7]  = '{0, 0,  0,  7,  7,  1, 7,  1, 32'h11110007,  0,  1,  4,  0,  1,  4,  0,  1, 0, 0,  32'h0};
    vecs[8]  = '{1, 9,  6,  7,  0,  0, 0,  0, 32'h0,         0,  1,  4,  0,  0,  0,  0,  1, 1, 7,  32'h11110007};
    vecs[9]  = '{1, 9,  2,  9,  0,  1, 9,  6, 32'h00000099,  0,  0,  0,  1,  0,  0,  0,  1, 0, 0,  32'h0};
    vecs[10] = '{1, 3,  1,  9,  0,  0, 0,  0, 32'h0,         0,  1,  2,  0,  0,  0,  0,  1, 1, 9,  32'h00000099};
    vecs[11] = '{1, 4,  2,  3,  0,  0, 0,  0, 32'h0,         0,  1,  1,  0,  0,  0,  0,  1, 0, 0,  32'h0};
    vecs[12] = '{1, 5,  5,  4,  3,  0, 0,  0, 32'h0,         0,  1,  2,  0,  1,  1,  0,  1, 0, 0,  32'h0};
    vecs[13] = '{1, 8,  7,  5,  3,  1, 3,  1, 32'h00000033,  1,  1,  5,  0,  0,  0,  1,  1, 0, 0,  32'h0};
    vecs[14] = '{1, 10, 1,  8,  4,  0, 0,  0, 32'h0,         0,  0,  0,  0,  0,  0,  0,  0, 1, 3,  32'h00000033};
    vecs[15] = '{0, 0,  0,  5,  10, 0, 0,  0, 32'h0,         0,  0,  0,  0,  0,  0,  0,  1, 0, 0,  32'h0};
    vecs[16] = '{1, 0,  3,  0,  0,  1, 0,  0, 32'h00000077,  0,  0,  0,  0,  0,  0,  0,  1, 0, 0,  32'h0};
    vecs[17] = '{0, 0,  0,  0,  0,  0, 0,  0, 32'h0,         0,  0,  0,  0,  0,  0,  0,  1, 0, 0,  32'h0};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].dv, vecs[i].drd, vecs[i].dtag, vecs[i].r1, vecs[i].r2,
            vecs[i].cv, vecs[i].crd, vecs[i].ctag, vecs[i].cdata, vecs[i].fl);
      #2;
      chk_outs($sformatf("vec%0d", i), vecs[i].e1b, vecs[i].e1t, vecs[i].e1f,
               vecs[i].e2b, vecs[i].e2t, vecs[i].e2f, vecs[i].erdy,
               vecs[i].ewe, vecs[i].ewa, vecs[i].ewd);
      @(posedge clk); #1;
    end

    // Back-to-back flush keeps RECOVER for a second cycle
    drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1);
    #2 chk("flush2.ready_a", 32'(disp_ready), 32'd1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1);
    #2 chk("flush2.ready_b", 32'(disp_ready), 32'd0);
    @(posedge clk); #1;
    idle();
    #2 chk("flush2.ready_c", 32'(disp_ready), 32'd0);
    @(posedge clk); #1;
    #2 chk("flush2.ready_d", 32'(disp_ready), 32'd1);
    @(posedge clk); #1;

    // Asynchronous reset with busy registers and a pending write
    drive(1, 12, 5, 0, 0, 1, 6, 0, 32'hCAFE0006, 0);
    @(posedge clk); #1;
    idle();
    rs1 = 12;
    #1;
    chk("arst.pre_busy", 32'(rs1_busy), 32'd1);
    chk("arst.pre_we",   32'(rf_we),    32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst.busy",  32'(rs1_busy), 32'd0);
    chk("arst.tag",   32'(rs1_tag),  32'd0);
    chk("arst.we",    32'(rf_we),    32'd0);
    chk("arst.waddr", 32'(rf_waddr), 32'd0);
    chk("arst.wdata", rf_wdata,      32'd0);
    chk("arst.ready", 32'(disp_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();

    // Randomized traffic against the behavioural model
    for (int n = 0; n < 400; n++) begin
      logic [4:0] crd;
      crd = 5'($urandom_range(0, 7));
      disp_valid   = 1'($urandom_range(0, 1));
      disp_rd      = 5'($urandom_range(0, 7));
      disp_tag     = 3'($urandom);
      rs1          = 5'($urandom_range(0, 7));
      rs2          = ($urandom_range(0, 3) == 0) ? crd : 5'($urandom_range(0, 7));
      commit_valid = 1'($urandom_range(0, 1));
      commit_rd    = crd;
      commit_tag   = ($urandom_range(0, 2) != 0) ? tag_m[crd] : 3'($urandom);
      commit_data  = $urandom;
      flush        = ($urandom_range(0, 19) == 0);
      #2;
      l1 = model_lookup(rs1);
      l2 = model_lookup(rs2);
      chk_outs($sformatf("rnd%0d", n), l1[4], l1[3:1], l1[0], l2[4], l2[3:1], l2[0],
               !recov_m, we_m, wa_m, wd_m);
      @(posedge clk);
      model_edge();
      #1;
    end

    idle();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
